udp_cfg_parser: RTL and testbench
=================================

UDP_CFG_PARSER -- requirements
Module: udp_cfg_parser

Interface
REQ-001 Parameter MAGIC, default 16'hA55A, required header tag in word0[31:16].
REQ-002 Parameter OP_WR, default 8'h01, the only accepted opcode, carried in word0[15:8].
REQ-003 Parameter MAX_LEN, default 8, maximum number of parameter words per packet.
REQ-004 Parameter CFG_INIT, default 192'h0, reset value of cfg_regs, with reg i at bits [24i+23:24i].
REQ-005 gmii_rx_clk  in  1  single clock; UDP receive domain.
REQ-006 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-007 rec_en  in  1  one received 32-bit payload word is valid this cycle.
REQ-008 rec_data  in  32  payload word, big-endian, first byte in bits [31:24].
REQ-009 rec_pkt_done  in  1  one-cycle pulse marking packet end.
REQ-010 rec_byte_num  in  16  payload byte count; sampled only when rec_pkt_done is high.
REQ-011 cfg_regs  out  192  eight 24-bit DSO configuration registers.
REQ-012 cfg_update  out  1  one-cycle pulse marking a commit.
REQ-013 cfg_mask  out  8  registers written by the last commit; held until the next commit.
REQ-014 pkt_ok_cnt  out  16  count of accepted packets, saturating.
REQ-015 pkt_err_cnt  out  16  count of rejected packets, saturating.
REQ-016 err_code  out  3  code of the last rejection; held until the next rejection.

Function
REQ-017 Packet format SHALL be: word0 = {MAGIC, op, len}; then len words of {addr[7:0], data[23:0]}; then one checksum word equal to the XOR of all preceding words.
REQ-018 The FSM SHALL have these states: IDLE, PARAM, CSUM, WAIT_END, DROP.
REQ-019 IDLE on rec_en SHALL check the header and go to PARAM, or go to DROP on error.
REQ-020 PARAM SHALL store each word in a MAX_LEN x 32 staging buffer; after the len-th word it SHALL go to CSUM.
REQ-021 CSUM on rec_en SHALL compare the word with the running XOR and go to WAIT_END (match) or DROP (error 5).
REQ-022 Header errors SHALL be: magic mismatch = error 1; op != OP_WR = error 2; len == 0 or len > MAX_LEN = error 3.
REQ-023 A parameter word with addr >= 8 SHALL set error 4; the remaining words go to DROP.
REQ-024 Size error 6 SHALL be set by any of: rec_en in WAIT_END (overlong packet); rec_pkt_done before WAIT_END; rec_byte_num != 4*(len+2).
REQ-025 Only the first detected error SHALL be recorded for a packet.
REQ-026 When rec_en and rec_pkt_done occur in the same cycle, the word SHALL be processed first and then the end-of-packet check made.
REQ-027 On rec_pkt_done in any state, the FSM SHALL return to IDLE and staging SHALL be cleared.
REQ-028 Commit SHALL be all-or-nothing. On rec_pkt_done in WAIT_END with no error, the next cycle SHALL update cfg_regs from staging in order (a duplicate addr: last word wins), pulse cfg_update, load cfg_mask, and increment pkt_ok_cnt.
REQ-029 On a rejected packet, the cycle after rec_pkt_done SHALL load err_code and increment pkt_err_cnt; cfg_regs SHALL be unchanged.
REQ-030 A rec_pkt_done with no preceding word SHALL be error 6.
REQ-031 Counters SHALL saturate at 16'hFFFF.
REQ-032 A new packet header arriving in the commit cycle SHALL be accepted without loss (zero-gap operation).
REQ-033 Latency from rec_pkt_done to cfg_update SHALL be exactly 1 cycle.

Reset
REQ-034 sys_rst_n low SHALL asynchronously force: FSM to IDLE; staging and running XOR cleared; cfg_regs = CFG_INIT; cfg_update = 0; cfg_mask = 0; both counters = 0; err_code = 0.
REQ-035 A reset mid-packet SHALL discard the packet; words arriving after release, until the next rec_pkt_done, SHALL be treated as a new packet and rejected per REQ-022..024.

Structure
REQ-036 Package udp_cfg_pkg SHALL hold the state encoding, the error codes (0 none, 1 magic, 2 op, 3 len, 4 addr, 5 csum, 6 size) and the register index constants.
REQ-037 Sub-module udp_cfg_stage SHALL implement the staging buffer: write pointer, clear, indexed read for commit.

Verification
REQ-038 Send A55A0102, 00000123, 05ABCDEF, checksum, byte_num 16 -> 1 cycle after done: reg0 = 000123, reg5 = ABCDEF, cfg_mask = 21, pkt_ok_cnt = 1.
REQ-039 Same packet with a corrupted checksum -> cfg_regs unchanged, err_code = 5, pkt_err_cnt = 1, no cfg_update.
REQ-040 Header A55A0100 -> err_code = 3; header 12340101 -> err_code = 1; extra word after checksum -> err_code = 6.
REQ-041 Parameter words 02000001 then 02000002 -> reg2 = 000002, cfg_mask = 04.
REQ-042 Assert reset after the 2nd word, then send a valid packet -> the valid packet commits with no residue from the aborted packet.
REQ-043 Back-to-back valid packets with the second header arriving in the commit cycle -> both commit, pkt_ok_cnt = 2.

Source files
------------

// File: rtl/udp_cfg_pkg.sv
// rtl/udp_cfg_pkg.sv - shared encodings and constants for the UDP configuration parser
package udp_cfg_pkg;

    localparam int REG_NUM = 8;
    localparam int REG_W   = 24;
    localparam int ADDR_W  = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PARAM    = 3'd1;
    localparam logic [2:0] S_CSUM     = 3'd2;
    localparam logic [2:0] S_WAIT_END = 3'd3;
    localparam logic [2:0] S_DROP     = 3'd4;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_MAGIC = 3'd1;
    localparam logic [2:0] ERR_OP    = 3'd2;
    localparam logic [2:0] ERR_LEN   = 3'd3;
    localparam logic [2:0] ERR_ADDR  = 3'd4;
    localparam logic [2:0] ERR_CSUM  = 3'd5;
    localparam logic [2:0] ERR_SIZE  = 3'd6;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udp_cfg_stage.sv
// rtl/udp_cfg_stage.sv - staging buffer holding parameter words until the packet is judged
module udp_cfg_stage #(
    parameter int MAX_LEN = 8,
    parameter int PTR_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_wr,
    input  logic [31:0]            i_wdata,
    output logic [PTR_W-1:0]       o_ptr,
    output logic [MAX_LEN*32-1:0]  o_buf
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [31:0]      r_mem [MAX_LEN];
    logic [PTR_W-1:0] r_ptr;

    // Clear wins over a same-cycle write: that word belongs to a packet being closed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
            for (int i = 0; i < MAX_LEN; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
            for (int i = 0; i < MAX_LEN; i++) r_mem[i] <= '0;
        end else if (i_wr && (r_ptr < PTR_W'(MAX_LEN))) begin
            r_mem[r_ptr[IDX_W-1:0]] <= i_wdata;
            r_ptr                   <= r_ptr + 1'b1;
        end
    end

    always_comb begin
        o_buf = '0;
        for (int i = 0; i < MAX_LEN; i++) o_buf[i*32 +: 32] = r_mem[i];
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/udp_cfg_parser.sv
// rtl/udp_cfg_parser.sv - parses UDP config packets and commits them atomically to cfg_regs
module udp_cfg_parser
    import udp_cfg_pkg::*;
#(
    parameter logic [15:0]  MAGIC    = 16'hA55A,
    parameter logic [7:0]   OP_WR    = 8'h01,
    parameter int           MAX_LEN  = 8,
    parameter logic [191:0] CFG_INIT = 192'h0
) (
    input  logic         gmii_rx_clk,
    input  logic         sys_rst_n,
    input  logic         rec_en,
    input  logic [31:0]  rec_data,
    input  logic         rec_pkt_done,
    input  logic [15:0]  rec_byte_num,
    output logic [191:0] cfg_regs,
    output logic         cfg_update,
    output logic [7:0]   cfg_mask,
    output logic [15:0]  pkt_ok_cnt,
    output logic [15:0]  pkt_err_cnt,
    output logic [2:0]   err_code
);

    localparam int         PTR_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0]   r_state;
    logic [2:0]   r_err;
    logic [31:0]  r_xor;
    logic [7:0]   r_len;
    logic [7:0]   r_cnt;
    logic [191:0] r_cfg_regs;
    logic         r_cfg_update;
    logic [7:0]   r_cfg_mask;
    logic [15:0]  r_ok_cnt;
    logic [15:0]  r_err_cnt;
    logic [2:0]   r_err_code;

    logic [2:0]            w_state_nx;
    logic [2:0]            w_err_nx;
    logic [2:0]            w_err_done;
    logic [31:0]           w_xor_nx;
    logic [7:0]            w_len_nx;
    logic [7:0]            w_cnt_nx;
    logic                  w_stg_wr;
    logic [15:0]           w_exp_bytes;
    logic [PTR_W-1:0]      w_ptr;
    logic [MAX_LEN*32-1:0] w_buf;
    logic [191:0]          w_cfg_nx;
    logic [7:0]            w_mask_nx;
    logic [7:0]            w_maddr;

    udp_cfg_stage #(.MAX_LEN(MAX_LEN), .PTR_W(PTR_W)) u_stage (
        .i_clk   (gmii_rx_clk),
        .i_rst_n (sys_rst_n),
        .i_clr   (rec_pkt_done),
        .i_wr    (w_stg_wr),
        .i_wdata (rec_data),
        .o_ptr   (w_ptr),
        .o_buf   (w_buf)
    );

    // Word processing first; the end-of-packet verdict below sees its result.
    always_comb begin
        w_state_nx = r_state;
        w_err_nx   = r_err;
        w_xor_nx   = r_xor;
        w_len_nx   = r_len;
        w_cnt_nx   = r_cnt;
        w_stg_wr   = 1'b0;
        if (rec_en) begin
            case (r_state)
                S_IDLE: begin
                    w_xor_nx = rec_data;
                    w_len_nx = rec_data[7:0];
                    w_cnt_nx = 8'd0;
                    if (rec_data[31:16] != MAGIC) begin
                        w_err_nx   = ERR_MAGIC;
                        w_state_nx = S_DROP;
                    end else if (rec_data[15:8] != OP_WR) begin
                        w_err_nx   = ERR_OP;
                        w_state_nx = S_DROP;
                    end else if ((rec_data[7:0] == 8'd0) || (rec_data[7:0] > MAX_LEN_B)) begin
                        w_err_nx   = ERR_LEN;
                        w_state_nx = S_DROP;
                    end else begin
                        w_state_nx = S_PARAM;
                    end
                end
                S_PARAM: begin
                    if (rec_data[31:24] >= 8'd8) begin
                        w_err_nx   = ERR_ADDR;
                        w_state_nx = S_DROP;
                    end else begin
                        w_stg_wr = 1'b1;
                        w_xor_nx = r_xor ^ rec_data;
                        w_cnt_nx = r_cnt + 8'd1;
                        if (r_cnt + 8'd1 == r_len) w_state_nx = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (rec_data == r_xor) begin
                        w_state_nx = S_WAIT_END;
                    end else begin
                        w_err_nx   = ERR_CSUM;
                        w_state_nx = S_DROP;
                    end
                end
                S_WAIT_END: begin
                    w_err_nx   = ERR_SIZE;
                    w_state_nx = S_DROP;
                end
                default: ;
            endcase
        end
    end

    assign w_exp_bytes = {6'd0, w_len_nx, 2'b00} + 16'd8;

    always_comb begin
        w_err_done = w_err_nx;
        if ((w_err_nx == ERR_NONE) &&
            ((w_state_nx != S_WAIT_END) || (rec_byte_num != w_exp_bytes)))
            w_err_done = ERR_SIZE;
    end

    // Replay staging in arrival order so a repeated address keeps its last value.
    always_comb begin
        w_cfg_nx  = r_cfg_regs;
        w_mask_nx = 8'd0;
        w_maddr   = 8'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_maddr = w_buf[i*32+24 +: 8];
            if ((int'(w_ptr) > i) && (w_maddr < 8'd8)) begin
                w_cfg_nx[w_maddr[ADDR_W-1:0]*REG_W +: REG_W] = w_buf[i*32 +: REG_W];
                w_mask_nx[w_maddr[ADDR_W-1:0]]               = 1'b1;
            end
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= S_IDLE;
            r_err        <= ERR_NONE;
            r_xor        <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_cfg_regs   <= CFG_INIT;
            r_cfg_update <= 1'b0;
            r_cfg_mask   <= '0;
            r_ok_cnt     <= '0;
            r_err_cnt    <= '0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_cfg_update <= 1'b0;
            if (rec_pkt_done) begin
                r_state <= S_IDLE;
                r_err   <= ERR_NONE;
                r_xor   <= '0;
                r_len   <= '0;
                r_cnt   <= '0;
                if (w_err_done == ERR_NONE) begin
                    r_cfg_regs   <= w_cfg_nx;
                    r_cfg_update <= 1'b1;
                    r_cfg_mask   <= w_mask_nx;
                    r_ok_cnt     <= sat_inc(r_ok_cnt);
                end else begin
                    r_err_code <= w_err_done;
                    r_err_cnt  <= sat_inc(r_err_cnt);
                end
            end else begin
                r_state <= w_state_nx;
                r_err   <= w_err_nx;
                r_xor   <= w_xor_nx;
                r_len   <= w_len_nx;
                r_cnt   <= w_cnt_nx;
            end
        end
    end

    assign cfg_regs    = r_cfg_regs;
    assign cfg_update  = r_cfg_update;
    assign cfg_mask    = r_cfg_mask;
    assign pkt_ok_cnt  = r_ok_cnt;
    assign pkt_err_cnt = r_err_cnt;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_udp_cfg_parser.sv
// tb/tb_udp_cfg_parser.sv - directed self-checking bench with a packet-level reference model
module tb_udp_cfg_parser;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rec_en;
    logic [31:0]  rec_data;
    logic         rec_pkt_done;
    logic [15:0]  rec_byte_num;
    logic [191:0] cfg_regs;
    logic         cfg_update;
    logic [7:0]   cfg_mask;
    logic [15:0]  pkt_ok_cnt;
    logic [15:0]  pkt_err_cnt;
    logic [2:0]   err_code;

    always #5 clk = ~clk;

    udp_cfg_parser dut (
        .gmii_rx_clk  (clk),
        .sys_rst_n    (rst_n),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .rec_byte_num (rec_byte_num),
        .cfg_regs     (cfg_regs),
        .cfg_update   (cfg_update),
        .cfg_mask     (cfg_mask),
        .pkt_ok_cnt   (pkt_ok_cnt),
        .pkt_err_cnt  (pkt_err_cnt),
        .err_code     (err_code)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    logic [23:0] m_regs [8];
    logic [7:0]  m_mask;
    logic        m_upd;
    logic [15:0] m_ok;
    logic [15:0] m_err;
    logic [2:0]  m_code;
    logic [31:0] pkt [$];
    logic [31:0] tq  [$];

    function automatic void chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [191:0] m_flat();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*24 +: 24] = m_regs[i];
        return r;
    endfunction

    // Judge the words seen since the last packet end, in the order the rules detect errors.
    function automatic int eval_pkt(input int bn);
        int n;
        int len;
        logic [31:0] x;
        n = pkt.size();
        if (n == 0) return 6;
        if (pkt[0][31:16] != 16'hA55A) return 1;
        if (pkt[0][15:8] != 8'h01) return 2;
        len = int'(pkt[0][7:0]);
        if (len == 0 || len > 8) return 3;
        x = pkt[0];
        for (int k = 1; k <= len; k++) begin
            if (k >= n) return 6;
            if (pkt[k][31:24] >= 8'd8) return 4;
            x = x ^ pkt[k];
        end
        if (n < len + 2) return 6;
        if (pkt[len+1] != x) return 5;
        if (n > len + 2) return 6;
        if (bn != 4 * (len + 2)) return 6;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 24'h0;
        m_mask = 8'h0;
        m_upd  = 1'b0;
        m_ok   = 16'h0;
        m_err  = 16'h0;
        m_code = 3'h0;
        pkt.delete();
    endtask

    task automatic model_done(input int bn);
        int e;
        int len;
        e = eval_pkt(bn);
        if (e == 0) begin
            len    = int'(pkt[0][7:0]);
            m_mask = 8'h0;
            for (int k = 1; k <= len; k++) begin
                m_regs[pkt[k][26:24]] = pkt[k][23:0];
                m_mask[pkt[k][26:24]] = 1'b1;
            end
            m_upd = 1'b1;
            if (m_ok != 16'hFFFF) m_ok = m_ok + 16'd1;
        end else begin
            m_code = 3'(e);
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
        pkt.delete();
    endtask

    task automatic cycle(input bit en, input logic [31:0] d, input bit done, input int bn);
        rec_en       = en;
        rec_data     = d;
        rec_pkt_done = done;
        rec_byte_num = 16'(bn);
        @(posedge clk);
        m_upd = 1'b0;
        if (en) pkt.push_back(d);
        if (done) model_done(bn);
        #1;
        rec_en       = 1'b0;
        rec_data     = 32'h0;
        rec_pkt_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 0);
    endtask

    task automatic push_csum();
        logic [31:0] x;
        x = 32'h0;
        foreach (tq[i]) x = x ^ tq[i];
        tq.push_back(x);
    endtask

    task automatic send(input int bn, input bit with_last);
        for (int i = 0; i < tq.size(); i++)
            cycle(1'b1, tq[i], with_last && (i == tq.size() - 1), bn);
        if (!with_last) cycle(1'b0, 32'h0, 1'b1, bn);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle(1'b0, 32'h0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("cfg_regs",    cfg_regs,           m_flat());
            chk("cfg_update",  192'(cfg_update),   192'(m_upd));
            chk("cfg_mask",    192'(cfg_mask),     192'(m_mask));
            chk("pkt_ok_cnt",  192'(pkt_ok_cnt),   192'(m_ok));
            chk("pkt_err_cnt", 192'(pkt_err_cnt),  192'(m_err));
            chk("err_code",    192'(err_code),     192'(m_code));
        end
    end

    initial begin
        rst_n        = 1'b1;
        rec_en       = 1'b0;
        rec_data     = 32'h0;
        rec_pkt_done = 1'b0;
        rec_byte_num = 16'h0;
        model_reset();
        #3;
        rst_n    = 1'b0;
        checking = 1'b1;
        idle(2);
        rst_n = 1'b1;
        chk("rst_regs", cfg_regs, 192'h0);
        chk("rst_ok",   192'(pkt_ok_cnt), 192'h0);
        chk("rst_code", 192'(err_code), 192'h0);
        idle(1);

        // Reference packet: two registers written.
        tq.delete();
        tq.push_back(32'hA55A0102); tq.push_back(32'h00000123); tq.push_back(32'h05ABCDEF);
        push_csum();
        chk("csum_lit", 192'(tq[3]), 192'hA0F1CDCE);
        send(16, 1'b1);
        chk("ok_reg0",   192'(cfg_regs[23:0]),    192'h000123);
        chk("ok_reg5",   192'(cfg_regs[143:120]), 192'hABCDEF);
        chk("ok_mask",   192'(cfg_mask),          192'h21);
        chk("ok_cnt",    192'(pkt_ok_cnt),        192'h1);
        chk("ok_update", 192'(cfg_update),        192'h1);
        idle(2);

        // Same packet with a bad checksum, end flagged on a separate cycle.
        tq[3] = 32'hA0F1CDCF;
        send(16, 1'b0);
        chk("csum_code", 192'(err_code),    192'h5);
        chk("csum_cnt",  192'(pkt_err_cnt), 192'h1);
        chk("csum_keep", 192'(cfg_regs[23:0]), 192'h000123);
        chk("csum_noup", 192'(cfg_update),  192'h0);
        idle(1);

        tq.delete(); tq.push_back(32'hA55A0100);
        send(4, 1'b1);
        chk("len0_code", 192'(err_code), 192'h3);
        tq.delete(); tq.push_back(32'h12340101);
        send(4, 1'b1);
        chk("magic_code", 192'(err_code), 192'h1);
        tq.delete();
        tq.push_back(32'hA55A0102); tq.push_back(32'h00000123); tq.push_back(32'h05ABCDEF);
        push_csum(); tq.push_back(32'h00000000);
        send(20, 1'b1);
        chk("long_code", 192'(err_code), 192'h6);
        idle(1);

        // Duplicate address: the later word wins.
        tq.delete();
        tq.push_back(32'hA55A0102); tq.push_back(32'h02000001); tq.push_back(32'h02000002);
        push_csum();
        send(16, 1'b1);
        chk("dup_reg2", 192'(cfg_regs[71:48]), 192'h000002);
        chk("dup_mask", 192'(cfg_mask),        192'h04);
        idle(1);

        tq.delete(); tq.push_back(32'hA55A0201); send(4, 1'b1);
        chk("op_code", 192'(err_code), 192'h2);
        tq.delete(); tq.push_back(32'hA55A0109); send(4, 1'b1);
        tq.delete(); tq.push_back(32'hA55A0101); tq.push_back(32'h08000000); push_csum();
        send(12, 1'b0);
        chk("addr_code", 192'(err_code), 192'h4);
        tq.delete(); tq.push_back(32'hA55A0102); tq.push_back(32'h00000001);
        send(16, 1'b0);
        tq.delete(); tq.push_back(32'hA55A0101); tq.push_back(32'h07000007); push_csum();
        send(8, 1'b1);
        chk("bn_keep", 192'(cfg_regs[191:168]), 192'h0);
        cycle(1'b0, 32'h0, 1'b1, 0);
        tq.delete(); tq.push_back(32'hA55A0108);
        for (int i = 0; i < 8; i++) tq.push_back({8'(i), 24'h100000 + 24'(i)});
        push_csum();
        send(40, 1'b1);
        chk("max_reg7", 192'(cfg_regs[191:168]), 192'h100007);
        idle(1);

        // Reset mid-packet, leftover words, then a clean packet.
        tq.delete(); tq.push_back(32'hA55A0102); tq.push_back(32'h00000777);
        send(16, 1'b1);
        idle(1);
        cycle(1'b1, 32'hA55A0102, 1'b0, 0);
        cycle(1'b1, 32'h00000777, 1'b0, 0);
        do_reset();
        cycle(1'b1, 32'h01000888, 1'b0, 0);
        cycle(1'b1, 32'hA4C9FEE6, 1'b1, 16);
        chk("resid_code", 192'(err_code), 192'h1);
        tq.delete(); tq.push_back(32'hA55A0101); tq.push_back(32'h03000333); push_csum();
        send(12, 1'b1);
        chk("rst_reg0", 192'(cfg_regs[23:0]),  192'h0);
        chk("rst_reg1", 192'(cfg_regs[47:24]), 192'h0);
        chk("rst_reg3", 192'(cfg_regs[95:72]), 192'h000333);
        chk("rst_mask", 192'(cfg_mask),        192'h08);
        idle(2);

        // Zero-gap: second header lands in the first packet's commit cycle.
        do_reset();
        tq.delete(); tq.push_back(32'hA55A0101); tq.push_back(32'h04000444); push_csum();
        send(12, 1'b1);
        tq.delete(); tq.push_back(32'hA55A0101); tq.push_back(32'h06000666); push_csum();
        send(12, 1'b1);
        chk("b2b_reg4", 192'(cfg_regs[119:96]),  192'h000444);
        chk("b2b_reg6", 192'(cfg_regs[167:144]), 192'h000666);
        chk("b2b_ok",   192'(pkt_ok_cnt),        192'h2);
        chk("b2b_mask", 192'(cfg_mask),          192'h40);
        idle(3);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
